// File: rtl/chess_pkg.sv
// Shared game-clock definitions: controller states, side encoding, time-word layout.
// Pure declarations, no logic and no latency.
// Not applicable: this file has no handshakes and applies no backpressure.
package chess_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    FLAG   = 2'd3
  } state_t;

  localparam logic SIDE_WHITE = 1'b0;
  localparam logic SIDE_BLACK = 1'b1;

  localparam logic [9:0] TIME_ZERO = 10'd0;

  // Countdown word layout {min[2:0], sec_tens[2:0], sec_ones[3:0]}, shared with the timer
  localparam int TIME_MIN_MSB  = 9;
  localparam int TIME_MIN_LSB  = 7;
  localparam int TIME_TENS_MSB = 6;
  localparam int TIME_TENS_LSB = 4;
  localparam int TIME_ONES_MSB = 3;
  localparam int TIME_ONES_LSB = 0;

  function automatic logic time_is_zero(input logic [9:0] t);
    return (t == TIME_ZERO);
  endfunction

endpackage

// File: rtl/chess_clock_ctrl_prescaler.sv
// Divides the system clock down to a one-cycle tick every TICK_DIV enabled cycles.
// The tick is combinational and is high while the count sits at TICK_DIV-1.
// Not applicable: this module has no handshakes; en=0 freezes the count, and clr wins over en.
module tick_prescaler #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count 0..TICK_DIV-1 while enabled; a clear restarts the second from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // A cleared second never emits its stale terminal tick
  assign tick = en && !clr && (r_cnt == CNT_MAX);

endmodule

// File: rtl/chess_clock_ctrl.sv
// Game controller: IDLE/RUN/PAUSED/FLAG sequencing, side to move, 1 s tick, flag fall.
// Every output is registered, one cycle behind its cause, except running, which is decoded from state.
// Not applicable: request pulses are always accepted or dropped, never stalled.
module chess_clock_ctrl
  import chess_pkg::*;
#(
  parameter int TICK_DIV   = 100000000,
  parameter int MOVE_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_req,
  input  logic                  pause_req,
  input  logic                  move_valid,
  input  logic                  move_side,
  input  logic [9:0]            countdown_white,
  input  logic [9:0]            countdown_black,
  output logic                  tick_1s,
  output logic                  side_to_move,
  output logic                  timer_load,
  output logic                  running,
  output logic                  flag_white,
  output logic                  flag_black,
  output logic                  illegal_turn,
  output logic [MOVE_CNT_W-1:0] move_count
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_side;
  logic                  r_tick;
  logic                  r_load;
  logic                  r_illegal;
  logic                  r_flag_w;
  logic                  r_flag_b;
  logic [MOVE_CNT_W-1:0] r_move_cnt;

  logic w_active_zero;
  logic w_new_game;
  logic w_flag_fall;
  logic w_presc_en;
  logic w_presc_clr;
  logic w_presc_tick;
  logic w_legal;
  logic w_illegal;

  // Only the side on move can run out of time; the idle side is frozen
  assign w_active_zero = time_is_zero((r_side == SIDE_BLACK) ? countdown_black : countdown_white);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: flag fall beats pause, which beats any move
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, FLAG: if (start_req) w_state_nxt = RUN;
      RUN: begin
        if (w_active_zero)  w_state_nxt = FLAG;
        else if (pause_req) w_state_nxt = PAUSED;
      end
      PAUSED:     if (start_req) w_state_nxt = RUN;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // Per-cycle actions decoded from state and requests, same priority as the next-state logic
  always_comb begin
    w_new_game  = 1'b0;
    w_flag_fall = 1'b0;
    w_presc_en  = 1'b0;
    w_legal     = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      IDLE, FLAG: w_new_game = start_req;
      RUN: begin
        if (w_active_zero) begin
          w_flag_fall = 1'b1;
        end else if (!pause_req) begin
          w_presc_en = 1'b1;
          if (move_valid) begin
            w_legal   = (move_side == r_side);
            w_illegal = (move_side != r_side);
          end
        end
      end
      default: ;
    endcase
  end

  // A legal move hands the new side a full second; a new game restarts the second too
  assign w_presc_clr = w_new_game | w_legal;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (w_presc_en),
    .clr  (w_presc_clr),
    .tick (w_presc_tick)
  );

  // Registered game status: side, flags, move counter and the one-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_side     <= SIDE_WHITE;
      r_tick     <= 1'b0;
      r_load     <= 1'b0;
      r_illegal  <= 1'b0;
      r_flag_w   <= 1'b0;
      r_flag_b   <= 1'b0;
      r_move_cnt <= '0;
    end else begin
      r_tick    <= w_presc_tick;
      r_load    <= w_new_game;
      r_illegal <= w_illegal;
      if (w_new_game) begin
        r_side     <= SIDE_WHITE;
        r_move_cnt <= '0;
        r_flag_w   <= 1'b0;
        r_flag_b   <= 1'b0;
      end else if (w_flag_fall) begin
        if (r_side == SIDE_BLACK) r_flag_b <= 1'b1;
        else                      r_flag_w <= 1'b1;
      end else if (w_legal) begin
        r_side <= ~r_side;
        if ((move_side == SIDE_BLACK) && (r_move_cnt != '1)) begin
          r_move_cnt <= r_move_cnt + MOVE_CNT_W'(1);
        end
      end
    end
  end

  assign running      = (r_state == RUN);
  assign tick_1s      = r_tick;
  assign timer_load   = r_load;
  assign illegal_turn = r_illegal;
  assign side_to_move = r_side;
  assign flag_white   = r_flag_w;
  assign flag_black   = r_flag_b;
  assign move_count   = r_move_cnt;

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Self-checking bench for chess_clock_ctrl: directed game scenarios pinned by literal
// expectations, then randomized play compared every cycle against a behavioural game model.
// Inputs change 1 ns after the falling edge; outputs are sampled on the falling edge.
module tb_chess_clock_ctrl;

  localparam int TD    = 4;
  localparam int MW    = 3;
  localparam int MAXC  = (1 << MW) - 1;
  localparam logic [9:0] NOM = 10'd300;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_req = 1'b0;
  logic          pause_req = 1'b0;
  logic          move_valid = 1'b0;
  logic          move_side = 1'b0;
  logic [9:0]    countdown_white = NOM;
  logic [9:0]    countdown_black = NOM;
  logic          tick_1s;
  logic          side_to_move;
  logic          timer_load;
  logic          running;
  logic          flag_white;
  logic          flag_black;
  logic          illegal_turn;
  logic [MW-1:0] move_count;

  chess_clock_ctrl #(
    .TICK_DIV   (TD),
    .MOVE_CNT_W (MW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_req       (start_req),
    .pause_req       (pause_req),
    .move_valid      (move_valid),
    .move_side       (move_side),
    .countdown_white (countdown_white),
    .countdown_black (countdown_black),
    .tick_1s         (tick_1s),
    .side_to_move    (side_to_move),
    .timer_load      (timer_load),
    .running         (running),
    .flag_white      (flag_white),
    .flag_black      (flag_black),
    .illegal_turn    (illegal_turn),
    .move_count      (move_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural game model: mode 0 idle, 1 running, 2 paused, 3 flagged.
  // phase = cycles already spent in the current second of the side on move.
  int m_mode  = 0;
  bit m_side  = 0;
  int m_phase = 0;
  int m_cnt   = 0;
  bit m_fw    = 0;
  bit m_fb    = 0;
  bit e_tick  = 0;
  bit e_load  = 0;
  bit e_ill   = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_mode = 0; m_side = 0; m_phase = 0; m_cnt = 0;
      m_fw = 0; m_fb = 0; e_tick = 0; e_load = 0; e_ill = 0;
    end else begin
      e_tick = 0; e_load = 0; e_ill = 0;
      if (m_mode == 0 || m_mode == 3) begin
        if (start_req) begin
          m_mode = 1; e_load = 1; m_side = 0; m_phase = 0; m_cnt = 0; m_fw = 0; m_fb = 0;
        end
      end else if (m_mode == 2) begin
        if (start_req) m_mode = 1;
      end else begin
        if ((m_side ? countdown_black : countdown_white) == 10'd0) begin
          m_mode = 3;
          if (m_side) m_fb = 1; else m_fw = 1;
        end else if (pause_req) begin
          m_mode = 2;
        end else if (move_valid && (move_side == m_side)) begin
          if (move_side) m_cnt = (m_cnt == MAXC) ? MAXC : m_cnt + 1;
          m_side  = !m_side;
          m_phase = 0;
        end else begin
          if (move_valid) e_ill = 1;
          m_phase = m_phase + 1;
          if (m_phase == TD) begin
            e_tick  = 1;
            m_phase = 0;
          end
        end
      end
    end
  end

  // Continuous comparison against the model whenever reset is released
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("m_running", running,      (m_mode == 1));
      chk("m_tick",    tick_1s,      e_tick);
      chk("m_load",    timer_load,   e_load);
      chk("m_illegal", illegal_turn, e_ill);
      chk("m_side",    side_to_move, m_side);
      chk("m_flag_w",  flag_white,   m_fw);
      chk("m_flag_b",  flag_black,   m_fb);
      chk("m_count",   move_count,   m_cnt);
    end
  end

  // Drive one cycle of inputs, then return on the following falling edge
  task automatic step(input bit r, input bit s, input bit p, input bit mv, input bit ms,
                      input logic [9:0] cw, input logic [9:0] cb);
    #1;
    rst = r; start_req = s; pause_req = p; move_valid = mv; move_side = ms;
    countdown_white = cw; countdown_black = cb;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, NOM, NOM);
  endtask

  function automatic logic [9:0] pick_time();
    if ($urandom_range(0, 19) == 0) return 10'd0;
    return 10'($urandom_range(1, 1023));
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_running", running, 0);
    chk("rst_tick",    tick_1s, 0);
    chk("rst_load",    timer_load, 0);
    chk("rst_side",    side_to_move, 0);
    chk("rst_count",   move_count, 0);
    chk("rst_flags",   {flag_white, flag_black, illegal_turn}, 0);
    idle();
    chk("idle_no_load", timer_load, 0);

    // New game: load pulse, ticks at 4, 8, 12 cycles after RUN entry
    step(0, 1, 0, 0, 0, NOM, NOM);
    chk("start_load",    timer_load, 1);
    chk("start_running", running, 1);
    chk("start_side",    side_to_move, 0);
    for (int i = 1; i <= 12; i++) begin
      idle();
      chk("tick_sched", tick_1s, (i % 4 == 0));
      if (i == 1) chk("load_one_cycle", timer_load, 0);
    end

    // White moves with the prescaler at 2: next tick a full 4 cycles after the commit
    idle();
    idle();
    step(0, 0, 0, 1, 0, NOM, NOM);
    chk("white_move_side", side_to_move, 1);
    for (int i = 1; i <= 4; i++) begin
      idle();
      chk("tick_after_move", tick_1s, (i == 4));
    end
    step(0, 0, 0, 1, 1, NOM, NOM);
    chk("black_move_side",  side_to_move, 0);
    chk("black_move_count", move_count, 1);

    // Black moves out of turn
    step(0, 0, 0, 1, 1, NOM, NOM);
    chk("illegal_pulse", illegal_turn, 1);
    chk("illegal_side",  side_to_move, 0);
    chk("illegal_count", move_count, 1);
    idle();
    chk("illegal_one_cycle", illegal_turn, 0);

    // Pause with the prescaler at 1, hold, then resume
    idle();
    idle();
    chk("tick_before_pause", tick_1s, 1);
    idle();
    step(0, 0, 1, 0, 0, NOM, NOM);
    chk("pause_running", running, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), NOM, NOM);
      chk("paused_tick",    tick_1s, 0);
      chk("paused_illegal", illegal_turn, 0);
      chk("paused_side",    side_to_move, 0);
    end
    step(0, 1, 0, 0, 0, NOM, NOM);
    chk("resume_running", running, 1);
    chk("resume_no_load", timer_load, 0);
    for (int i = 1; i <= 3; i++) begin
      idle();
      chk("tick_after_resume", tick_1s, (i == 3));
    end

    // Black runs out of time while also committing a move
    step(0, 0, 0, 1, 0, NOM, NOM);
    chk("pre_flag_side", side_to_move, 1);
    step(0, 0, 0, 1, 1, NOM, 10'd0);
    chk("flag_black",    flag_black, 1);
    chk("flag_white",    flag_white, 0);
    chk("flag_running",  running, 0);
    chk("flag_no_toggle", side_to_move, 1);
    chk("flag_count",    move_count, 1);
    for (int i = 0; i < 8; i++) begin
      idle();
      chk("flag_no_tick", tick_1s, 0);
      chk("flag_sticky",  flag_black, 1);
    end
    step(0, 1, 0, 0, 0, NOM, NOM);
    chk("restart_load",  timer_load, 1);
    chk("restart_flags", {flag_white, flag_black}, 0);
    chk("restart_run",   running, 1);
    chk("restart_count", move_count, 0);

    // Asynchronous reset with the prescaler at 3
    idle();
    idle();
    idle();
    #1 rst = 1'b1;
    #1;
    chk("arst_all_zero", {tick_1s, side_to_move, timer_load, running, flag_white, flag_black,
                          illegal_turn, 3'(move_count)}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_tick", tick_1s, 0);
      chk("arst_idle",    running, 0);
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("post_arst_no_tick", tick_1s, 0);
    end

    // Randomized play, checked every cycle against the model
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 499) == 0),
           1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 1)),
           pick_time(), pick_time());
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
